// File: rtl/cgra_col_ctrl.sv
// CGRA column controller: configures requested columns one at a time in ascending order, releases them together, tracks per-column PCs.
// Request to first col_start is 1 cycle; imem_gnt_i throttles fetches; optional kernel-tag cache under CGRA_COL_CTRL_KCACHE_EN.
module cgra_col_ctrl #(
    parameter int N_COL     = 4,
    parameter int PC_W      = 5,
    parameter int IMEM_AW   = 7,
    parameter int KID_W     = 4,
    parameter int MUL_STALL = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_COL-1:0]        acc_req_i,
    input  logic [KID_W-1:0]        ker_id_i,
    input  logic [PC_W-1:0]         ker_n_instr_i,
    input  logic [IMEM_AW-1:0]      ker_imem_add_i,
    output logic                    imem_req_o,
    output logic [IMEM_AW-1:0]      imem_radd_o,
    input  logic                    imem_gnt_i,
    input  logic                    imem_rvalid_i,
    input  logic [N_COL-1:0]        br_req_i,
    input  logic [N_COL*PC_W-1:0]   br_add_i,
    input  logic [N_COL-1:0]        rcs_stall_i,
    input  logic [N_COL-1:0]        data_stall_i,
    input  logic [N_COL-1:0]        exec_end_i,
    output logic [N_COL*PC_W-1:0]   pc_o,
    output logic [N_COL-1:0]        conf_we_o,
    output logic [N_COL-1:0]        conf_re_o,
    output logic [N_COL-1:0]        pc_e_o,
    output logic [N_COL-1:0]        col_e_o,
    output logic [N_COL-1:0]        col_rst_o,
    output logic [N_COL-1:0]        conf_ack_o,
    output logic [N_COL-1:0]        col_start_o,
    output logic                    acc_ack_o,
    output logic [N_COL-1:0]        acc_end_o
);

    typedef enum logic [1:0] {G_IDLE, G_CONF, G_DONE} g_state_t;
    typedef enum logic [2:0] {C_RESET, C_IDLE, C_CONF, C_SYNCH, C_EXEC, C_DONE} c_state_t;

    localparam logic [2:0] STALL_RLD = 3'(MUL_STALL - 1);

    g_state_t               g_q, g_d;
    c_state_t               cs_q [N_COL];
    c_state_t               cs_d [N_COL];
    logic [N_COL-1:0]       req_q;
    logic [IMEM_AW-1:0]     radd_q;
    logic [PC_W-1:0]        issued_q, rcvd_q;
    logic [PC_W-1:0]        pc_q [N_COL];
    logic [2:0]             scnt_q [N_COL];
    logic [N_COL-1:0]       hit, stall;
    logic                   any_conf, pend_found;

`ifdef CGRA_COL_CTRL_KCACHE_EN
    logic [KID_W-1:0]       tag_q [N_COL];
    logic [N_COL-1:0]       tag_vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_q <= '0;
            for (int c = 0; c < N_COL; c++) tag_q[c] <= '0;
        end else if (acc_ack_o) begin
            for (int c = 0; c < N_COL; c++) begin
                if (req_q[c]) begin
                    tag_q[c]     <= ker_id_i;
                    tag_vld_q[c] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int c = 0; c < N_COL; c++) hit[c] = tag_vld_q[c] && (tag_q[c] == ker_id_i);
    end
`else
    assign hit = '0;
`endif

    always_comb begin
        stall = '0;
        for (int c = 0; c < N_COL; c++)
            stall[c] = (cs_q[c] == C_EXEC) && rcs_stall_i[c] && (scnt_q[c] != 3'd0);
    end

    always_comb begin
        conf_we_o   = '0;
        conf_re_o   = '0;
        pc_e_o      = '0;
        col_e_o     = '0;
        col_rst_o   = '0;
        conf_ack_o  = '0;
        col_start_o = '0;
        acc_end_o   = '0;
        imem_req_o  = 1'b0;
        any_conf    = 1'b0;
        pend_found  = 1'b0;
        acc_ack_o   = (g_q == G_CONF);
        g_d         = g_q;
        for (int c = 0; c < N_COL; c++) begin
            cs_d[c] = cs_q[c];
            if (cs_q[c] == C_CONF) any_conf = 1'b1;
            if (req_q[c] && cs_q[c] != C_SYNCH) acc_ack_o = 1'b0;
        end
        // Lowest unconfigured column gets the slot; a column still executing an older kernel holds everyone back.
        if (g_q == G_CONF && !any_conf) begin
            for (int c = 0; c < N_COL; c++) begin
                if (!pend_found && req_q[c] && cs_q[c] != C_SYNCH) begin
                    pend_found = 1'b1;
                    if (cs_q[c] == C_IDLE) col_start_o[c] = 1'b1;
                end
            end
        end
        for (int c = 0; c < N_COL; c++) begin
            case (cs_q[c])
                C_RESET: begin
                    col_rst_o[c] = 1'b1;
                    cs_d[c]      = C_IDLE;
                end
                C_IDLE: if (col_start_o[c]) cs_d[c] = C_CONF;
                C_CONF: begin
                    col_e_o[c] = 1'b1;
                    if (hit[c] || rcvd_q == ker_n_instr_i) begin
                        col_rst_o[c] = 1'b1;
                        cs_d[c]      = C_SYNCH;
                    end else begin
                        conf_we_o[c] = 1'b1;
                        pc_e_o[c]    = imem_rvalid_i;
                        if (issued_q < ker_n_instr_i) imem_req_o = 1'b1;
                    end
                end
                C_SYNCH: begin
                    col_e_o[c]    = 1'b1;
                    conf_ack_o[c] = 1'b1;
                    if (acc_ack_o) cs_d[c] = C_EXEC;
                end
                C_EXEC: begin
                    col_e_o[c]   = 1'b1;
                    conf_re_o[c] = 1'b1;
                    pc_e_o[c]    = ~exec_end_i[c] & ~stall[c] & ~data_stall_i[c];
                    if (exec_end_i[c] && !stall[c] && !data_stall_i[c]) cs_d[c] = C_DONE;
                end
                C_DONE: begin
                    col_rst_o[c] = 1'b1;
                    acc_end_o[c] = 1'b1;
                    cs_d[c]      = C_IDLE;
                end
                default: cs_d[c] = C_RESET;
            endcase
        end
        case (g_q)
            G_IDLE:  if (acc_req_i != '0) g_d = G_CONF;
            G_CONF:  if (acc_ack_o) g_d = G_DONE;
            default: g_d = G_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            g_q      <= G_IDLE;
            req_q    <= '0;
            radd_q   <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
        end else begin
            g_q <= g_d;
            if (g_q == G_IDLE && acc_req_i != '0) begin
                req_q  <= acc_req_i;
                radd_q <= ker_imem_add_i;
            end else if (imem_req_o && imem_gnt_i) begin
                radd_q <= radd_q + 1'b1;
            end
            // Only one column configures at a time, so the fetch counters are shared.
            if (col_start_o != '0) begin
                issued_q <= '0;
                rcvd_q   <= '0;
            end else begin
                if (imem_req_o && imem_gnt_i) issued_q <= issued_q + 1'b1;
                if (imem_rvalid_i && conf_we_o != '0) rcvd_q <= rcvd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_COL; c++) begin
                cs_q[c]   <= C_RESET;
                pc_q[c]   <= '0;
                scnt_q[c] <= STALL_RLD;
            end
        end else begin
            for (int c = 0; c < N_COL; c++) begin
                cs_q[c] <= cs_d[c];
                if (col_rst_o[c])     pc_q[c] <= '0;
                else if (br_req_i[c]) pc_q[c] <= br_add_i[c*PC_W +: PC_W];
                else if (pc_e_o[c])   pc_q[c] <= pc_q[c] + 1'b1;
                // Re-arm only once the stall request is gone, so one held request costs exactly MUL_STALL-1 cycles.
                if (col_rst_o[c])     scnt_q[c] <= STALL_RLD;
                else if (stall[c])    scnt_q[c] <= scnt_q[c] - 1'b1;
                else if (scnt_q[c] == 3'd0 && pc_e_o[c] && !rcs_stall_i[c])
                    scnt_q[c] <= STALL_RLD;
            end
        end
    end

    assign imem_radd_o = radd_q;

    always_comb begin
        pc_o = '0;
        for (int c = 0; c < N_COL; c++) pc_o[c*PC_W +: PC_W] = pc_q[c];
    end

endmodule

// File: tb/tb_cgra_col_ctrl.sv
// Directed bench for cgra_col_ctrl with a per-cycle behavioural model and literal scenario checks.
module tb_cgra_col_ctrl;
    localparam int N  = 4;
    localparam int PW = 5;
    localparam int AW = 7;
    localparam int KW = 4;
    localparam int MS = 3;
`ifdef CGRA_COL_CTRL_KCACHE_EN
    localparam bit KC = 1'b1;
`else
    localparam bit KC = 1'b0;
`endif
    localparam int P_RST = 0, P_IDLE = 1, P_CONF = 2, P_SYN = 3, P_EXE = 4, P_DONE = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]    acc_req;
    logic [KW-1:0]   ker_id;
    logic [PW-1:0]   n_instr;
    logic [AW-1:0]   ker_add;
    logic            imem_req_o;
    logic [AW-1:0]   imem_radd_o;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [N-1:0]    br_req;
    logic [N*PW-1:0] br_add;
    logic [N-1:0]    rcs, dstall, exec_end;
    logic [N*PW-1:0] pc_o;
    logic [N-1:0]    conf_we_o, conf_re_o, pc_e_o, col_e_o, col_rst_o, conf_ack_o, col_start_o, acc_end_o;
    logic            acc_ack_o;

    always #5 clk = ~clk;

    cgra_col_ctrl #(.N_COL(N), .PC_W(PW), .IMEM_AW(AW), .KID_W(KW), .MUL_STALL(MS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .acc_req_i(acc_req), .ker_id_i(ker_id),
        .ker_n_instr_i(n_instr), .ker_imem_add_i(ker_add), .imem_req_o(imem_req_o),
        .imem_radd_o(imem_radd_o), .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid),
        .br_req_i(br_req), .br_add_i(br_add), .rcs_stall_i(rcs), .data_stall_i(dstall),
        .exec_end_i(exec_end), .pc_o(pc_o), .conf_we_o(conf_we_o), .conf_re_o(conf_re_o),
        .pc_e_o(pc_e_o), .col_e_o(col_e_o), .col_rst_o(col_rst_o), .conf_ack_o(conf_ack_o),
        .col_start_o(col_start_o), .acc_ack_o(acc_ack_o), .acc_end_o(acc_end_o)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    bit sim_done = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    endtask

    // Behavioural model: column phases with closed-form configuration timing
    // (gnt always high, rvalid one cycle after each grant => n+2 cycles per miss, 1 per hit).
    int m_ph [N];
    int m_k  [N];
    int m_pc [N];
    int m_su [N];
    int m_tag[N];
    bit m_tv [N];
    int m_g;
    logic [N-1:0] m_req;
    int m_addr;

    logic [N-1:0]    e_we, e_re, e_pce, e_cole, e_rst, e_ack_c, e_start, e_end, e_st;
    logic            e_req, e_ack;
    logic [N*PW-1:0] e_pc;
    logic [AW-1:0]   e_radd;

    int fetch_q[$];
    int ack_cnt = 0;
    int ack_cyc = 0;
    int end_cnt[N];
    logic [N-1:0] re_after;
    bit ack_prev = 1'b0;
    logic rv_next;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_ph[c] = P_RST; m_k[c] = 0; m_pc[c] = 0; m_su[c] = 0; m_tag[c] = 0; m_tv[c] = 1'b0;
        end
        m_g = 0; m_req = '0; m_addr = 0;
    endtask

    task automatic model_eval();
        int n, len;
        bit any_conf, found, hitc;
        n = int'(n_instr);
        {e_we, e_re, e_pce, e_cole, e_rst, e_ack_c, e_start, e_end, e_st} = '0;
        e_req = 1'b0;
        any_conf = 1'b0;
        for (int c = 0; c < N; c++) if (m_ph[c] == P_CONF) any_conf = 1'b1;
        for (int c = 0; c < N; c++) begin
            hitc = KC && m_tv[c] && (m_tag[c] == int'(ker_id));
            case (m_ph[c])
                P_RST:  e_rst[c] = 1'b1;
                P_CONF: begin
                    e_cole[c] = 1'b1;
                    len = hitc ? 1 : n + 2;
                    if (m_k[c] == len - 1) e_rst[c] = 1'b1;
                    else begin
                        e_we[c] = 1'b1;
                        if (m_k[c] < n) e_req = 1'b1;
                        if (m_k[c] >= 1 && m_k[c] <= n) e_pce[c] = 1'b1;
                    end
                end
                P_SYN:  begin e_cole[c] = 1'b1; e_ack_c[c] = 1'b1; end
                P_EXE:  begin
                    e_cole[c] = 1'b1; e_re[c] = 1'b1;
                    e_st[c]   = rcs[c] && (m_su[c] < MS - 1);
                    e_pce[c]  = !exec_end[c] && !e_st[c] && !dstall[c];
                end
                P_DONE: begin e_rst[c] = 1'b1; e_end[c] = 1'b1; end
                default: ;
            endcase
        end
        found = 1'b0;
        if (m_g == 1 && !any_conf)
            for (int c = 0; c < N; c++)
                if (!found && m_req[c] && m_ph[c] != P_SYN) begin
                    found = 1'b1;
                    if (m_ph[c] == P_IDLE) e_start[c] = 1'b1;
                end
        e_ack = (m_g == 1);
        for (int c = 0; c < N; c++) if (m_req[c] && m_ph[c] != P_SYN) e_ack = 1'b0;
        e_radd = AW'(m_addr);
        for (int c = 0; c < N; c++) e_pc[c*PW +: PW] = PW'(m_pc[c]);
    endtask

    task automatic model_advance();
        for (int c = 0; c < N; c++) begin
            if (e_rst[c])       m_pc[c] = 0;
            else if (br_req[c]) m_pc[c] = int'(br_add[c*PW +: PW]);
            else if (e_pce[c])  m_pc[c] = (m_pc[c] + 1) % (1 << PW);
            if (m_ph[c] != P_EXE || !rcs[c]) m_su[c] = 0;
            else if (e_st[c])                m_su[c]++;
            case (m_ph[c])
                P_RST:  m_ph[c] = P_IDLE;
                P_IDLE: if (e_start[c]) begin m_ph[c] = P_CONF; m_k[c] = 0; end
                P_CONF: if (e_rst[c]) m_ph[c] = P_SYN; else m_k[c]++;
                P_SYN:  if (e_ack) m_ph[c] = P_EXE;
                P_EXE:  if (exec_end[c] && !e_st[c] && !dstall[c]) m_ph[c] = P_DONE;
                default: m_ph[c] = P_IDLE;
            endcase
        end
        if (m_g == 0 && acc_req != '0) begin
            m_g = 1; m_req = acc_req; m_addr = int'(ker_add);
        end else begin
            if (e_req) m_addr = (m_addr + 1) % (1 << AW);
            if (m_g == 1 && e_ack) begin
                m_g = 2;
                for (int c = 0; c < N; c++) if (m_req[c]) begin m_tag[c] = int'(ker_id); m_tv[c] = 1'b1; end
            end else if (m_g == 2) m_g = 0;
        end
    endtask

    // Compare process: imem responder, per-cycle model comparison, observation records.
    initial begin
        model_reset();
        rv_next = 1'b0;
        for (int c = 0; c < N; c++) end_cnt[c] = 0;
        while (!sim_done) begin
            @(negedge clk);
            imem_rvalid = rv_next;
            #2;
            cyc++;
            if (!rst_n) model_reset();
            model_eval();
            check("imem_req",  imem_req_o,  e_req);
            check("imem_radd", imem_radd_o, e_radd);
            check("pc",        pc_o,        e_pc);
            check("conf_we",   conf_we_o,   e_we);
            check("conf_re",   conf_re_o,   e_re);
            check("pc_e",      pc_e_o,      e_pce);
            check("col_e",     col_e_o,     e_cole);
            check("col_rst",   col_rst_o,   e_rst);
            check("conf_ack",  conf_ack_o,  e_ack_c);
            check("col_start", col_start_o, e_start);
            check("acc_ack",   acc_ack_o,   e_ack);
            check("acc_end",   acc_end_o,   e_end);
            if (imem_req_o && imem_gnt) fetch_q.push_back(int'(imem_radd_o));
            if (ack_prev) re_after = conf_re_o;
            ack_prev = acc_ack_o;
            if (acc_ack_o) begin ack_cnt++; ack_cyc = cyc; end
            for (int c = 0; c < N; c++) if (acc_end_o[c]) end_cnt[c]++;
            if (rst_n) model_advance();
            rv_next = rst_n && imem_req_o && imem_gnt;
        end
    end

    task automatic do_req(input logic [N-1:0] mask, input int kid, input int n, input int add,
                          output int lat, output int nfetch, output int base);
        int a0, rc;
        @(negedge clk);
        acc_req = mask; ker_id = KW'(kid); n_instr = PW'(n); ker_add = AW'(add);
        base = fetch_q.size();
        #3;
        rc = cyc; a0 = ack_cnt;
        for (int i = 0; i < 200 && ack_cnt == a0; i++) begin @(negedge clk); #3; end
        if (ack_cnt == a0) check("ack_timeout", 0, 1);
        lat = ack_cyc - rc;
        nfetch = fetch_q.size() - base;
        @(negedge clk);
        acc_req = '0;
    endtask

    task automatic end_exec(input logic [N-1:0] mask);
        @(negedge clk); exec_end = mask;
        repeat (3) @(negedge clk);
        exec_end = '0;
    endtask

    initial begin
        int lat, nf, base, lows, e0;
        rst_n = 1'b0; acc_req = '0; ker_id = '0; n_instr = '0; ker_add = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; br_req = '0; br_add = '0;
        rcs = '0; dstall = '0; exec_end = '0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_col_rst", col_rst_o, 4'hF);
        check("rst_pc", pc_o, '0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Two-column configuration from 0x10.
        do_req(4'b0101, 3, 3, 16, lat, nf, base);
        #3;
        check("s1_nfetch", nf, 6);
        for (int i = 0; i < 6 && base + i < fetch_q.size(); i++) check("s1_addr", fetch_q[base+i], 16 + i);
        check("s1_ack_lat", lat, 13);
        check("s1_exec_together", re_after, 4'b0101);

        // ALU stall held 5 cycles.
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rcs[0] = 1'b1; #3;
            if (!pc_e_o[0]) lows++;
        end
        @(negedge clk); rcs = '0;
        check("stall_cycles", lows, 2);

        // Branch overrides increment.
        @(negedge clk); br_req[2] = 1'b1; br_add[2*PW +: PW] = 5'd7; #3;
        check("br_pce", pc_e_o[2], 1'b1);
        @(negedge clk); br_req = '0; #3;
        check("br_pc", pc_o[2*PW +: PW], 5'd7);

        // exec_end held back by data stall.
        e0 = end_cnt[0];
        @(negedge clk); exec_end[0] = 1'b1; dstall[0] = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("dstall_hold", end_cnt[0] - e0, 0);
        @(negedge clk); dstall[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); exec_end[0] = 1'b0; #3;
        check("dstall_end_pulse", end_cnt[0] - e0, 1);
        end_exec(4'b0100);

        // Same kernel again.
        do_req(4'b0101, 3, 3, 16, lat, nf, base);
        check("rep_nfetch", nf, KC ? 0 : 6);
        check("rep_ack_lat", lat, KC ? 5 : 13);
        end_exec(4'b0101);
        do_req(4'b0001, 3, 3, 16, lat, nf, base);
        check("one_nfetch", nf, KC ? 0 : 3);
        check("one_ack_lat", lat, KC ? 3 : 7);
        end_exec(4'b0001);

        // Reset mid-configuration.
        @(negedge clk); acc_req = 4'b0101; ker_id = 4'd5; n_instr = 5'd3; ker_add = 7'h10;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; acc_req = '0; #3;
        check("mid_rst_col_rst", col_rst_o, 4'hF);
        check("mid_rst_req", imem_req_o, 1'b0);
        check("mid_rst_radd", imem_radd_o, 7'h00);
        check("mid_rst_we", conf_we_o, 4'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_req(4'b0101, 3, 3, 16, lat, nf, base);
        check("post_rst_nfetch", nf, 6);
        if (nf > 0) check("post_rst_addr0", fetch_q[base], 16);
        check("post_rst_ack_lat", lat, 13);
        end_exec(4'b0101);
        repeat (3) @(negedge clk);

        sim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
